// File: rtl/fp21_normalize_round.sv
// fp21_normalize_round
//   Normalize / round-to-nearest-even / pack stage of the FP21 add/sub
//   datapath. Drives the raw mantissa sum out to an external 16-bit
//   leading-zero counter, consumes its registered count one edge later,
//   and produces an FP21 word {sign, exp[6:0], frac[12:0]} (bias BIAS)
//   with zero / overflow / underflow flags. Fixed 3-edge latency, one
//   beat per clock, no stall. Saturating event counters track overflow
//   and underflow results.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid            input beat valid (no backpressure)
//   in_sign/exp/mant    adder result: mant = {carry, hidden, frac[13:1], sticky}
//   lzc_array           registered mantissa handed to the external LZC
//   lzc_value           LZC result for lzc_array, registered externally
//   out_valid/out_data  packed FP21 result
//   out_zero/ovf/unf    exact zero / overflow to inf / flush to zero
//   cnt_clear           clears both event counters
//   ovf_count/unf_count saturating event counts
module fp21_normalize_round #(
  parameter int unsigned BIAS  = 63,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sign,
  input  logic [6:0]       in_exp,
  input  logic [15:0]      in_mant,
  output logic [15:0]      lzc_array,
  input  logic [3:0]       lzc_value,
  output logic             out_valid,
  output logic [20:0]      out_data,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_unf,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] ovf_count,
  output logic [CNT_W-1:0] unf_count
);

  // All-ones biased exponent encodes infinity.
  localparam logic signed [8:0] EXP_MAX = 9'(2 * BIAS + 1);

  // Stage 1: input capture, mantissa goes to the LZC.
  logic        s1_valid_q, s1_sign_q;
  logic [6:0]  s1_exp_q;
  logic [15:0] s1_mant_q;

  // Stage 2: aligned with the LZC's registered count.
  logic        s2_valid_q, s2_sign_q;
  logic [6:0]  s2_exp_q;
  logic [15:0] s2_mant_q;

  // Stage 3: output registers.
  logic             out_valid_q, out_zero_q, out_ovf_q, out_unf_q;
  logic [20:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0] ovf_cnt_q, unf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_mant_q  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_sign_q  <= in_sign;
      s1_exp_q   <= in_exp;
      s1_mant_q  <= in_mant;
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_exp_q   <= s1_exp_q;
      s2_mant_q  <= s1_mant_q;
    end
  end

  assign lzc_array = s1_mant_q;

  // Normalize, round, classify.
  logic [15:0]       shifted;
  logic [14:0]       norm;
  logic              sticky;
  logic              rnd_up;
  logic [13:0]       frac_inc;
  logic signed [8:0] e_norm, e_rnd;
  logic              is_zero, is_ovf, is_unf;

  always_comb begin
    shifted  = '0;
    norm     = '0;
    sticky   = 1'b0;
    e_norm   = '0;
    if (lzc_value == 4'd0) begin
      // Carry out: shift right one, the dropped LSB only feeds sticky.
      norm   = s2_mant_q[15:1];
      sticky = s2_mant_q[0];
      e_norm = $signed({2'b00, s2_exp_q}) + 9'sd1;
    end else begin
      shifted = s2_mant_q << (lzc_value - 4'd1);
      norm    = shifted[14:0];
      e_norm  = $signed({2'b00, s2_exp_q}) + 9'sd1 - $signed({5'b00000, lzc_value});
    end

    // norm[14] is the hidden bit, norm[13:1] the fraction, norm[0] the round bit.
    rnd_up   = norm[0] & (sticky | norm[1]);
    frac_inc = {1'b0, norm[13:1]} + {13'b0, rnd_up};
    // A fraction carry out means the significand became 10.000..; the
    // low 13 bits are already zero, so only the exponent moves.
    e_rnd    = e_norm + (frac_inc[13] ? 9'sd1 : 9'sd0);

    is_zero  = (s2_mant_q == 16'h0000);
    is_ovf   = !is_zero && (e_rnd >= EXP_MAX);
    is_unf   = !is_zero && (e_rnd <= 9'sd0);

    if (is_zero)     out_data_d = '0;
    else if (is_ovf) out_data_d = {s2_sign_q, 7'h7F, 13'h0000};
    else if (is_unf) out_data_d = {s2_sign_q, 20'h00000};
    else             out_data_d = {s2_sign_q, e_rnd[6:0], frac_inc[12:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= s2_valid_q;
      out_zero_q  <= s2_valid_q & is_zero;
      out_ovf_q   <= s2_valid_q & is_ovf;
      out_unf_q   <= s2_valid_q & is_unf;
      if (s2_valid_q) out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      if (out_valid_q && out_ovf_q && !(&ovf_cnt_q)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
      if (out_valid_q && out_unf_q && !(&unf_cnt_q)) unf_cnt_q <= unf_cnt_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;
  assign ovf_count = ovf_cnt_q;
  assign unf_count = unf_cnt_q;

endmodule

// File: tb/tb_fp21_normalize_round.sv
// Directed-vector and streaming bench for fp21_normalize_round. The
// external leading-zero counter is modelled as one register of lzc_array.
module tb_fp21_normalize_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_sign = 1'b0;
  logic [6:0]  in_exp = '0;
  logic [15:0] in_mant = '0;
  logic [15:0] lzc_array;
  logic [3:0]  lzc_value;
  logic        out_valid, out_zero, out_ovf, out_unf;
  logic [20:0] out_data;
  logic        cnt_clear = 1'b0;
  logic [7:0]  ovf_count, unf_count;

  always #5 clk = ~clk;

  fp21_normalize_round #(.BIAS(63), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sign(in_sign),
    .in_exp(in_exp), .in_mant(in_mant), .lzc_array(lzc_array),
    .lzc_value(lzc_value), .out_valid(out_valid), .out_data(out_data),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf),
    .cnt_clear(cnt_clear), .ovf_count(ovf_count), .unf_count(unf_count)
  );

  function automatic logic [3:0] lzc_of(input logic [15:0] a);
    for (int i = 15; i >= 0; i--) if (a[i]) return 4'(15 - i);
    return 4'd15;
  endfunction

  logic [3:0] lzc_q = '0;
  always_ff @(posedge clk) lzc_q <= lzc_of(lzc_array);
  assign lzc_value = lzc_q;

  typedef struct packed {
    logic        v;
    logic [20:0] d;
    logic        z, o, u;
  } exp_t;

  typedef struct packed {
    logic        sg;
    logic [6:0]  ex;
    logic [15:0] m;
    logic [20:0] d;
    logic        z, o, u;
  } vec_t;

  // Reference: find the MSB, keep 14 significant bits, round the
  // discarded remainder to nearest-even.
  function automatic exp_t ref_model(input logic sg, input logic [6:0] ex, input logic [15:0] m);
    exp_t r;
    int p, sh, sig, rem, half, e, mi;
    r = '0;
    r.v = 1'b1;
    if (m == 16'h0) begin
      r.z = 1'b1;
      return r;
    end
    p = 15;
    while (!m[p]) p--;
    mi = int'(m);
    sh = p - 13;
    if (sh > 0) begin
      sig  = mi >> sh;
      rem  = mi & ((1 << sh) - 1);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (sig % 2) == 1)) sig++;
    end else begin
      sig = mi << (-sh);
    end
    e = int'(ex) + p - 14;
    if (sig >= (1 << 14)) begin
      sig = sig >> 1;
      e++;
    end
    if (e >= 127) begin
      r.o = 1'b1;
      r.d = {sg, 7'h7F, 13'h0};
    end else if (e <= 0) begin
      r.u = 1'b1;
      r.d = {sg, 20'h0};
    end else begin
      r.d = {sg, 7'(e), 13'(sig)};
    end
    return r;
  endfunction

  int   n_vec = 0, n_err = 0;
  exp_t pipe [3];
  int   exp_ovf = 0, exp_unf = 0;
  logic [15:0] prev_m = '0;

  // One clock: check what is due now, advance the expected pipeline,
  // then drive the next inputs.
  task automatic cycle(input logic v, input logic sg, input logic [6:0] ex,
                       input logic [15:0] m, input exp_t x, input logic clr,
                       input logic rb);
    exp_t due;
    @(negedge clk);
    due = pipe[2];
    n_vec++;
    if (due.v) begin
      if ({out_valid, out_data, out_zero, out_ovf, out_unf} !== {1'b1, due.d, due.z, due.o, due.u}) begin
        n_err++;
        $display("FAIL result: got v=%b d=%06h z%b o%b u%b, want v=1 d=%06h z%b o%b u%b",
                 out_valid, out_data, out_zero, out_ovf, out_unf, due.d, due.z, due.o, due.u);
      end
    end else if ({out_valid, out_zero, out_ovf, out_unf} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle: got v=%b z%b o%b u%b, want all 0", out_valid, out_zero, out_ovf, out_unf);
    end
    n_vec++;
    if (ovf_count !== 8'(exp_ovf) || unf_count !== 8'(exp_unf)) begin
      n_err++;
      $display("FAIL counters: got ovf=%0d unf=%0d, want ovf=%0d unf=%0d",
               ovf_count, unf_count, exp_ovf, exp_unf);
    end
    n_vec++;
    if (lzc_array !== prev_m) begin
      n_err++;
      $display("FAIL lzc_array: got %04h, want %04h", lzc_array, prev_m);
    end

    if (rb || clr) begin
      exp_ovf = 0;
      exp_unf = 0;
    end else begin
      if (due.v && due.o && exp_ovf < 255) exp_ovf++;
      if (due.v && due.u && exp_unf < 255) exp_unf++;
    end
    if (rb) begin
      pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
      prev_m  = '0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = v ? x : exp_t'('0);
      prev_m  = m;
    end
    rst       = rb;
    cnt_clear = clr;
    in_valid  = rb ? 1'b0 : v;
    in_sign   = sg;
    in_exp    = ex;
    in_mant   = m;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 7'd0, 16'h0, '0, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic sg, input logic [6:0] ex, input logic [15:0] m, input logic clr);
    cycle(1'b1, sg, ex, m, ref_model(sg, ex, m), clr, 1'b0);
  endtask

  vec_t tbl [18];

  initial begin
    tbl[0]  = '{1'b0, 7'd63,  16'h4000, 21'h07E000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 7'd63,  16'h8000, 21'h080000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 7'd63,  16'hFFFF, 21'h082000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 7'd63,  16'h0010, 21'h06A000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 7'd63,  16'h0000, 21'h000000, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 7'd126, 16'h8000, 21'h0FE000, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 7'd5,   16'h0010, 21'h100000, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 7'd63,  16'h8002, 21'h080000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 7'd63,  16'h8006, 21'h080002, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 7'd63,  16'h4003, 21'h07E002, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 7'd63,  16'h4000, 21'h17E000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 7'd1,   16'h2000, 21'h000000, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 7'd2,   16'h2000, 21'h002000, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 7'd126, 16'h7FFF, 21'h0FE000, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 7'd126, 16'h7FFE, 21'h0FDFFF, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 7'd63,  16'h0000, 21'h000000, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 7'd63,  16'h0001, 21'h062000, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 7'd63,  16'h8003, 21'h080001, 1'b0, 1'b0, 1'b0};

    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
    repeat (2) @(posedge clk);

    // Reset state of the data register (flags/counters/lzc_array are
    // checked inside every cycle).
    @(negedge clk);
    n_vec++;
    if (out_data !== 21'h0) begin
      n_err++;
      $display("FAIL reset out_data: got %06h, want 000000", out_data);
    end

    // Directed table, back to back.
    for (int i = 0; i < 18; i++)
      cycle(1'b1, tbl[i].sg, tbl[i].ex, tbl[i].m,
            exp_t'({1'b1, tbl[i].d, tbl[i].z, tbl[i].o, tbl[i].u}), 1'b0, 1'b0);
    repeat (3) idle();

    // Overflow counter saturation.
    for (int i = 0; i < 300; i++) beat(1'b0, 7'd126, 16'h8000, 1'b0);
    repeat (3) idle();
    // Clear coincident with overflow events in flight.
    repeat (3) beat(1'b0, 7'd126, 16'h8000, 1'b0);
    beat(1'b0, 7'd126, 16'h8000, 1'b1);
    repeat (2) beat(1'b0, 7'd126, 16'h8000, 1'b0);
    repeat (4) idle();

    // Random streaming with bubbles.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else beat(1'($urandom), 7'($urandom_range(1, 126)),
                16'($urandom >> $urandom_range(0, 31)), 1'b0);
    end

    // Reset with two beats in flight.
    beat(1'b0, 7'd126, 16'h8000, 1'b0);
    beat(1'b1, 7'd2,   16'h0010, 1'b0);
    cycle(1'b0, 1'b0, 7'd0, 16'h0, '0, 1'b0, 1'b1);
    repeat (3) idle();
    beat(1'b0, 7'd63, 16'h4000, 1'b0);
    beat(1'b0, 7'd63, 16'hFFFF, 1'b0);
    beat(1'b0, 7'd126, 16'h8000, 1'b0);
    repeat (5) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp21_normalize_round.md
Name: fp21_normalize_round

Overview:
- Downstream consumer of the 16-bit leading-zero counter in the FP21 add/sub datapath.
- Takes the raw un-normalized mantissa sum, exponent and sign from the adder stage, and drives the mantissa to the counter.
- Consumes the registered count, then normalizes, rounds to nearest-even and packs an FP21 word: 1 sign, 7 exponent (bias 63), 13 fraction.
- Fully pipelined: one result per clock, fixed latency, plus saturating exception counters.

Parameters:
- BIAS, 63, exponent bias.
- CNT_W, 8, width of the saturating overflow/underflow event counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid; no backpressure, sampled every edge.
- in_sign  in  1  result sign from the adder.
- in_exp  in  7  biased exponent of the larger operand.
- in_mant  in  16  raw sum: [15] carry, [14] hidden-bit position, [13:1] fraction, [0] sticky.
- lzc_array  out  16  mantissa driven to the LZC (registered stage-1 copy).
- lzc_value  in  4  leading-zero count of lzc_array, 0..15, returned one edge later.
- out_valid  out  1  result valid.
- out_data  out  21  {sign, exp[6:0], frac[12:0]}.
- out_zero  out  1  result is exact zero.
- out_ovf  out  1  result overflowed to infinity.
- out_unf  out  1  result flushed to zero.
- cnt_clear  in  1  clears both event counters.
- ovf_count  out  CNT_W  saturating count of out_ovf beats.
- unf_count  out  CNT_W  saturating count of out_unf beats.

Behaviour:
- Pipeline, edge k samples input:
  - S1 @k: register valid/sign/exp/mant; lzc_array = S1 mant.
  - S2 @k+1: copy S1; the external counter registers lzc_value for this mantissa on the same edge.
  - S3 @k+2: normalize/round/pack into the output registers.
- Latency: out_valid high in the cycle after edge k+2.
- Throughput: 1 beat/clk; bubbles propagate as out_valid=0.
- There is no stall. The counter has no enable, so all stages advance every edge.
- Zero: S2 mant==0 → out_data=0 (+0), out_zero=1. lzc_value is ignored for zero mantissas.
- lz=0 (carry set): n = mant>>1; sticky s = mant[0]; e = exp+1.
- lz≥1: n = mant<<(lz-1); s = 0; e = exp+1-lz.
- e is computed in 9-bit signed arithmetic.
- After normalization n[14]=1. Fraction f = n[13:1]; round bit r = n[0].
- Rounding is RNE: increment f if r & (s | f[0]). If f wraps from 0x1FFF, set f=0 and e=e+1.
- Overflow: e ≥ 127 after rounding → {sign,7'h7F,13'h0}, out_ovf=1.
- Underflow: e ≤ 0 → {sign,20'h0}, out_unf=1. Subnormals are flushed, not produced.
- out_zero, out_ovf and out_unf are mutually exclusive. All three are 0 when out_valid=0.
- out_data is don't-care when out_valid=0, but holds its last value.
- Counters: increment on out_valid&out_ovf and on out_valid&out_unf. They saturate at 2^CNT_W-1 (no wrap).
- Counter priority: rst > cnt_clear > increment. A clear coincident with an event yields 0.
- Reset: every register clears to 0, including lzc_array, all outputs and both counters. In-flight beats are dropped with no spurious out_valid. The first valid output follows 3 edges after the first post-reset in_valid.

Test Plan:
Bench models the LZC as a 1-cycle register of lzc_array; exp=63 unless stated.
- Unity: mant=0x4000, sign=0 → out_data=0x07E000 three edges later; flags 0.
- Carry renormalize: mant=0x8000 → 0x080000. Carry with round-up: mant=0xFFFF → f wraps, out_data=0x082000.
- Cancellation: mant=0x0010 (lz=11) → 0x06A000. Then mant=0x0000 → 0x000000 with out_zero=1.
- Exceptions:
  - exp=126, mant=0x8000 → 0x0FE000, out_ovf=1, ovf_count=1.
  - sign=1, exp=5, mant=0x0010 → 0x100000, out_unf=1, unf_count=1.
  - 300 overflow beats → ovf_count stays 255.
  - cnt_clear with a coincident overflow → 0.
- Streaming: back-to-back random beats with bubbles → outputs match the reference model in order, exactly 3 edges after input, with no drops.
- Reset mid-stream: rst for 1 cycle with 2 beats in flight → out_valid=0 for 3 cycles, counters 0, subsequent beats correct.
